// File: rtl/mult_pkg.sv
// Shared types and constants for the EX-stage multiply / HI-LO unit.
// alu_op encodings let EX glue derive is_signed from the decoded op.
package mult_pkg;

   localparam int MULT_WIDTH = 32;

   localparam logic [3:0] ALU_OP_MULT  = 4'b0110;
   localparam logic [3:0] ALU_OP_MULTU = 4'b0111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      COMMIT = 2'd2
   } mult_state_t;

   function automatic logic is_signed_op(input logic [3:0] alu_op);
      return alu_op == ALU_OP_MULT;
   endfunction

endpackage

// File: rtl/mult_hilo_sequencer.sv
// Iterative shift-add mult/multu that owns HI/LO and stalls EX readers.
// MULT_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier is zero.
module mult_hilo_sequencer
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             rd_req,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   mult_state_t        state;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;
   logic               neg;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   mplier_nx;
   logic [2*WIDTH-1:0] prod;
   logic               last_step;

   // The most negative operand negates to itself, which reads as 2^(W-1) unsigned.
   assign mag_a = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
   assign mag_b = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

   assign mplier_nx = mplier >> 1;
   assign prod      = neg ? -acc : acc;

`ifdef MULT_EARLY_TERM_EN
   assign last_step = (count == CW'(WIDTH - 1)) || (mplier_nx == '0);
`else
   assign last_step = (count == CW'(WIDTH - 1));
`endif

   assign busy  = (state != IDLE);
   assign stall = busy & (rd_req | start);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
         neg    <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                  mcand  <= {{WIDTH{1'b0}}, mag_a};
                  mplier <= mag_b;
                  acc    <= '0;
                  count  <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (mplier[0]) begin
                  acc <= acc + mcand;
               end
               mcand  <= mcand << 1;
               mplier <= mplier_nx;
               count  <= count + 1'b1;
               if (last_step) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               {hi, lo} <= prod;
               done     <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_hilo_sequencer.sv
// Directed self-checking bench for mult_hilo_sequencer.
// Inputs change 1ns after each rising edge; outputs are sampled 2ns after.
module tb_mult_hilo_sequencer;
   import mult_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         is_signed;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         rd_req;
   logic         busy;
   logic         stall;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int           vecs = 0;
   int           errs = 0;
   logic [63:0]  model;

   always #5 clk = ~clk;

   mult_hilo_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .op_a      (op_a),
      .op_b      (op_b),
      .rd_req    (rd_req),
      .busy      (busy),
      .stall     (stall),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int run_len(input int early);
`ifdef MULT_EARLY_TERM_EN
      return early;
`else
      return W;
`endif
   endfunction

   task automatic run_mult(input string tag, input logic sgn,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [63:0] exp, input int early);
      int run;
      int n;
      bit held;
      run       = run_len(early);
      is_signed = sgn;
      op_a      = a;
      op_b      = b;
      start     = 1'b1;
      step();
      start     = 1'b0;
      is_signed = 1'b0;
      op_a      = '0;
      op_b      = '0;
      n         = 0;
      held      = 1'b1;
      #1;
      while (done !== 1'b1 && n < 100) begin
         if ({hi, lo} !== model || busy !== 1'b1) held = 1'b0;
         step();
         #1;
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'(run + 1));
      chk({tag, " hold"}, 64'(held), 64'd1);
      chk({tag, " product"}, {hi, lo}, exp);
      chk({tag, " busy@done"}, 64'(busy), 64'd0);
      model = exp;
      step();
      #1;
      chk({tag, " done pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int c;
      bit ok;
      bit saw2;
      rst       = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      op_a      = '0;
      op_b      = '0;
      rd_req    = 1'b0;
      model     = '0;
      step();
      step();
      rst = 1'b0;
      #1;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset stall", 64'(stall), 64'd0);
      chk("reset hilo", {hi, lo}, 64'd0);

      step();
      run_mult("multu 3x5", is_signed_op(ALU_OP_MULTU), 32'd3, 32'd5,
               64'h0000_0000_0000_000F, 3);
      run_mult("mult -2x3", is_signed_op(ALU_OP_MULT), 32'hFFFF_FFFE, 32'd3,
               64'hFFFF_FFFF_FFFF_FFFA, 2);
      run_mult("multu max", is_signed_op(ALU_OP_MULTU), 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
      run_mult("mult minint", is_signed_op(ALU_OP_MULT), 32'h8000_0000,
               32'h8000_0000, 64'h4000_0000_0000_0000, 32);
      run_mult("mult -7x-3", is_signed_op(ALU_OP_MULT), 32'hFFFF_FFF9,
               32'hFFFF_FFFD, 64'd21, 2);
      run_mult("multu x0", is_signed_op(ALU_OP_MULTU), 32'h0000_1234,
               32'd0, 64'd0, 1);

      // mfhi/mflo held off while busy, plus a second mult issued mid-flight
      is_signed = 1'b0;
      op_a      = 32'h0001_0000;
      op_b      = 32'h0001_2345;
      start     = 1'b1;
      step();
      start  = 1'b0;
      op_a   = '0;
      op_b   = '0;
      step();
      rd_req = 1'b1;
      c      = 1;
      ok     = 1'b1;
      saw2   = 1'b0;
      while (c < 100) begin
         #1;
         if (done === 1'b1) break;
         if (stall !== 1'b1) ok = 1'b0;
         if (start && stall === 1'b1) saw2 = 1'b1;
         step();
         c++;
         if (c == 3) begin
            start     = 1'b1;
            is_signed = 1'b1;
            op_a      = 32'd5;
            op_b      = 32'd9;
         end
         if (c == 6) begin
            start     = 1'b0;
            is_signed = 1'b0;
            op_a      = '0;
            op_b      = '0;
         end
      end
      chk("stall latency", 64'(c), 64'(run_len(17) + 1));
      chk("stall held", 64'(ok), 64'd1);
      chk("stall 2nd start", 64'(saw2), 64'd1);
      chk("stall @done", 64'(stall), 64'd0);
      chk("stall product", {hi, lo}, 64'h0000_0001_2345_0000);
      rd_req = 1'b0;
      step();
      #1;
      chk("2nd start ignored", 64'(busy), 64'd0);
      chk("2nd start hilo", {hi, lo}, 64'h0000_0001_2345_0000);

      // reset in the middle of RUN aborts and clears HI/LO
      op_a  = 32'hFFFF_FFFF;
      op_b  = 32'hFFFF_FFFF;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort hilo", {hi, lo}, 64'd0);
      chk("abort done", 64'(done), 64'd0);
      ok = 1'b1;
      repeat (3) begin
         step();
         #1;
         if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      end
      chk("abort quiet", 64'(ok), 64'd1);
      model = '0;
      run_mult("multu 7x6", is_signed_op(ALU_OP_MULTU), 32'd7, 32'd6,
               64'd42, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
